inst_fetch_buffer: RTL and testbench

INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/inst_fetch_buffer.sv | 112 +++++++++++
 tb/tb_inst_fetch_buffer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch buffer: instruction width,
// instruction field layout and the fetch FSM state encoding.
package fetch_pkg;

  localparam int INST_W = 8;

  // Field order fixes the bit positions: op[7:6], src1[5:4], src2[3:2], dest[1:0].
  typedef struct packed {
    logic [1:0] op;
    logic [1:0] src1;
    logic [1:0] src2;
    logic [1:0] dest;
  } fetch_inst_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with full/empty flags, same-cycle push/pop
// and a synchronous clear that overrides both.
module fetch_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: walks program memory from PC 0 into a small FIFO
// feeding decode. Macro FETCH_LOOP_EN makes RUN wrap to PC 0 until flushed.
module inst_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_flush,
  input  logic              i_load_we,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [INST_W-1:0] i_load_data,
  input  logic [ADDR_W:0]   i_prog_len,
  output logic [INST_W-1:0] o_inst,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [ADDR_W-1:0] o_inst_pc,
  output logic              o_busy,
  output logic              o_done
);

  localparam int ENTRY_W = ADDR_W + INST_W;

  fetch_state_e        r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_done;
  logic [INST_W-1:0]   r_mem [2**ADDR_W];

  logic [ENTRY_W-1:0]  w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_last;

  assign o_inst_valid = !w_empty;
  assign w_pop        = !w_empty && i_inst_ready;
  assign w_push       = (r_state == ST_RUN) && (!w_full || w_pop);
  assign w_last       = ({1'b0, r_pc} == (i_prog_len - (ADDR_W+1)'(1)));
  assign o_inst       = o_inst_valid ? w_head[INST_W-1:0] : '0;
  assign o_inst_pc    = o_inst_valid ? w_head[ENTRY_W-1:INST_W] : '0;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = r_done;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({r_pc, r_mem[r_pc]}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Program memory is deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge i_clk) begin
    if (i_load_we && (r_state == ST_IDLE)) r_mem[i_load_addr] <= i_load_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_flush) begin
        r_state <= ST_IDLE;
        r_pc    <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              r_pc <= '0;
              if (i_prog_len == '0) r_done  <= 1'b1;
              else                  r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (w_push) begin
              if (w_last) begin
`ifdef FETCH_LOOP_EN
                r_pc <= '0;
`else
                r_state <= ST_DRAIN;
`endif
              end else begin
                r_pc <= r_pc + ADDR_W'(1);
              end
            end
          end
          ST_DRAIN: begin
            if (w_empty) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: directed steps plus randomized
// programs and readiness, checked against an ordered program-memory model.
module tb_inst_fetch_buffer;
  import fetch_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2;
  localparam int MEM_N  = 1 << ADDR_W;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              start     = 1'b0;
  logic              flush     = 1'b0;
  logic              load_we   = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [7:0]        load_data = '0;
  logic [ADDR_W:0]   prog_len  = '0;
  logic              ready     = 1'b0;
  logic [7:0]        inst;
  logic              inst_valid;
  logic [ADDR_W-1:0] inst_pc;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;
  logic [7:0] modelMem [MEM_N];

  inst_fetch_buffer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_flush      (flush),
    .i_load_we    (load_we),
    .i_load_addr  (load_addr),
    .i_load_data  (load_data),
    .i_prog_len   (prog_len),
    .o_inst       (inst),
    .o_inst_valid (inst_valid),
    .i_inst_ready (ready),
    .o_inst_pc    (inst_pc),
    .o_busy       (busy),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic f, input logic r);
    start = s;
    flush = f;
    ready = r;
  endtask

  task automatic loadWord(input int addr, input logic [7:0] data);
    @(negedge clk);
    load_we   = 1'b1;
    load_addr = ADDR_W'(addr);
    load_data = data;
    modelMem[addr] = data;
  endtask

  task automatic loadRandomProgram();
    fetch_inst_t w;
    for (int i = 0; i < MEM_N; i++) begin
      w = fetch_inst_t'($urandom_range(255));
      loadWord(i, w);
    end
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // Start a program, deliver it with random readiness and compare every head
  // against the model; poke=1 also tries a write and a restart while busy.
  task automatic runProgram(input int len, input int readyPct, input int stallCycles, input bit poke);
    int expIdx = 0, xfers = 0, firstValid = -1, lastXfer = -1;
    int doneCnt = 0, doneAt = -1, busyAt1 = 0, busySeen = 0;
    logic r;
    @(negedge clk);
    prog_len = (ADDR_W+1)'(len);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int cyc = 1; cyc < 400; cyc++) begin
      @(negedge clk);
      start   = 1'b0;
      load_we = 1'b0;
      if (cyc == 1) busyAt1 = int'(busy);
      if (busy) busySeen = 1;
      if (done) begin
        doneCnt++;
        if (doneAt < 0) doneAt = cyc;
      end
      if (inst_valid) begin
        if (firstValid < 0) firstValid = cyc;
        checkOutput("head_pc_inst", 32'({inst_pc, inst}),
                    32'({ADDR_W'(expIdx), modelMem[expIdx % MEM_N]}));
      end
      r = (cyc > stallCycles) && (int'($urandom_range(99)) < readyPct);
      if (poke && cyc == 3) begin
        start     = 1'b1;
        load_we   = 1'b1;
        load_addr = ADDR_W'(1);
        load_data = ~modelMem[1];
      end
      ready = r;
      if (inst_valid && r) begin
        expIdx++;
        xfers++;
        lastXfer = cyc;
      end
      if (doneAt >= 0 && cyc >= doneAt + 3) break;
    end
    ready = 1'b0;
    checkOutput("xfer_count", 32'(xfers), 32'(len));
    checkOutput("done_count", 32'(doneCnt), 32'd1);
    checkOutput("busy_end", 32'(busy), 32'd0);
    checkOutput("valid_end", 32'(inst_valid), 32'd0);
    if (len > 0) begin
      checkOutput("busy_after_start", 32'(busyAt1), 32'd1);
      checkOutput("first_valid_cycle", 32'(firstValid), 32'd2);
      if (readyPct == 100 && stallCycles == 0)
        checkOutput("back_to_back", 32'(lastXfer - firstValid), 32'(len - 1));
    end else begin
      checkOutput("zero_done_cycle", 32'(doneAt), 32'd1);
      checkOutput("zero_no_valid", 32'(firstValid), 32'hFFFF_FFFF);
      checkOutput("zero_never_busy", 32'(busySeen), 32'd0);
    end
  endtask

  initial begin
    int doneSeen;
    int idx;
    logic r;

    $display("[TB] reset state");
    #2;
    checkOutput("rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_inst", 32'(inst), 32'd0);
    checkOutput("rst_pc", 32'(inst_pc), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    loadWord(0, 8'h1B);
    loadWord(1, 8'h42);
    loadWord(2, 8'h87);
    loadWord(3, 8'hFF);
    for (int i = 4; i < MEM_N; i++) loadWord(i, 8'(i * 17 + 3));
    @(negedge clk);
    load_we = 1'b0;

`ifdef FETCH_LOOP_EN
    $display("[TB] looping fetch prog_len=3");
    @(negedge clk);
    prog_len = 5'd3;
    applyStimulus(1'b1, 1'b0, 1'b0);
    idx = 0;
    doneSeen = 0;
    for (int cyc = 1; cyc < 60; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) doneSeen++;
      if (inst_valid)
        checkOutput("loop_head", 32'({inst_pc, inst}),
                    32'({ADDR_W'(idx % 3), modelMem[idx % 3]}));
      r = (int'($urandom_range(99)) < 70);
      ready = r;
      if (inst_valid && r) idx++;
    end
    checkOutput("loop_min_xfers", 32'(idx >= 6), 32'd1);
    checkOutput("loop_no_done", 32'(doneSeen), 32'd0);
    checkOutput("loop_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    checkOutput("loop_flush_busy", 32'(busy), 32'd0);
    checkOutput("loop_flush_valid", 32'(inst_valid), 32'd0);
    checkOutput("loop_flush_done", 32'(done), 32'd0);
`else
    $display("[TB] directed program, ready held high");
    runProgram(4, 100, 0, 1'b0);

    $display("[TB] directed program, 5 stalled cycles");
    runProgram(4, 100, 5, 1'b0);

    $display("[TB] zero-length program");
    runProgram(0, 100, 0, 1'b0);

    $display("[TB] flush with two buffered");
    @(negedge clk);
    prog_len = 5'd8;
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_flush_valid", 32'(inst_valid), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("flush_valid", 32'(inst_valid), 32'd0);
    checkOutput("flush_busy", 32'(busy), 32'd0);
    doneSeen = int'(done);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      doneSeen += int'(done);
    end
    checkOutput("flush_no_done", 32'(doneSeen), 32'd0);
    runProgram(4, 100, 0, 1'b0);

    $display("[TB] write and start while busy are ignored");
    runProgram(6, 60, 0, 1'b1);
    runProgram(6, 100, 0, 1'b0);

    $display("[TB] reset mid-run keeps program memory");
    @(negedge clk);
    prog_len = 5'd10;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(inst_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_done", 32'(done), 32'd0);
    runProgram(10, 80, 0, 1'b0);

    $display("[TB] randomized programs");
    for (int n = 0; n < 6; n++) begin
      loadRandomProgram();
      runProgram(int'($urandom_range(1, MEM_N)), int'($urandom_range(30, 100)),
                 int'($urandom_range(0, 3)), 1'b0);
    end
    runProgram(MEM_N, 100, 0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
